// File: rtl/time_keeper.sv
// time_keeper: Nixie clock time base with prescaler, checked load, field edit and deferred tick.
// Optional alarm compare/latch compiled in with TIME_KEEPER_ALARM_EN.
module time_keeper #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int CNT_W = 27
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       mode24,
  input  logic       run,
  input  logic [2:0] cursorPos,
  input  logic       up,
  input  logic       down,
  input  logic       loadValid,
  input  logic [5:0] loadHour,
  input  logic [5:0] loadMinute,
  input  logic [5:0] loadSecond,
  input  logic [5:0] alarmHour,
  input  logic [5:0] alarmMinute,
  input  logic       alarmArm,
  input  logic       alarmAck,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       pm,
  output logic       secTick,
  output logic       loadErr,
  output logic       alarm
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_HZ - 1);
  logic [5:0] true_hour, true_minute, true_second;
  logic [5:0] adv_hour, adv_minute, adv_second;
  logic [5:0] ed_hour, ed_minute, ed_second;
  logic [CNT_W-1:0] cnt;
  logic pending, sec_tick_q, load_err_q;
  logic tick_raw, load_ok, edit_ok, apply, sec_wrap, min_wrap;
  always_comb begin
    tick_raw   = run && cnt == CNT_MAX;
    load_ok    = loadValid && loadHour <= 6'd23 && loadMinute <= 6'd59 && loadSecond <= 6'd59;
    edit_ok    = !loadValid && (up ^ down) &&
                 (cursorPos == 3'b001 || cursorPos == 3'b010 || cursorPos == 3'b100);
    apply      = !loadValid && !edit_ok && (tick_raw || pending);
    sec_wrap   = true_second == 6'd59;
    min_wrap   = true_minute == 6'd59;
    adv_second = sec_wrap ? 6'd0 : true_second + 6'd1;
    adv_minute = !sec_wrap ? true_minute : min_wrap ? 6'd0 : true_minute + 6'd1;
    adv_hour   = !(sec_wrap && min_wrap) ? true_hour :
                 true_hour == 6'd23 ? 6'd0 : true_hour + 6'd1;
    // Edits touch only the selected field and never carry
    ed_second  = cursorPos != 3'b001 ? true_second :
                 up ? (sec_wrap ? 6'd0 : true_second + 6'd1) :
                 (true_second == 6'd0 ? 6'd59 : true_second - 6'd1);
    ed_minute  = cursorPos != 3'b010 ? true_minute :
                 up ? (min_wrap ? 6'd0 : true_minute + 6'd1) :
                 (true_minute == 6'd0 ? 6'd59 : true_minute - 6'd1);
    ed_hour    = cursorPos != 3'b100 ? true_hour :
                 up ? (true_hour == 6'd23 ? 6'd0 : true_hour + 6'd1) :
                 (true_hour == 6'd0 ? 6'd23 : true_hour - 6'd1);
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      true_hour   <= '0;
      true_minute <= '0;
      true_second <= '0;
      cnt         <= '0;
      pending     <= 1'b0;
      sec_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sec_tick_q <= apply;
      load_err_q <= loadValid && !load_ok;
      cnt        <= load_ok ? '0 : !run ? cnt : tick_raw ? '0 : cnt + CNT_W'(1);
      if (load_ok) begin
        true_hour   <= loadHour;
        true_minute <= loadMinute;
        true_second <= loadSecond;
        pending     <= 1'b0;
      end else if (edit_ok) begin
        true_hour   <= ed_hour;
        true_minute <= ed_minute;
        true_second <= ed_second;
        pending     <= pending | tick_raw;
      end else if (loadValid) begin
        pending     <= pending | tick_raw;
      end else if (apply) begin
        true_hour   <= adv_hour;
        true_minute <= adv_minute;
        true_second <= adv_second;
        pending     <= 1'b0;
      end
    end
  end
`ifdef TIME_KEEPER_ALARM_EN
  logic alarm_q, alarm_set;
  always_comb alarm_set = apply && alarmArm && adv_hour == alarmHour &&
                          adv_minute == alarmMinute && adv_second == 6'd0;
  always_ff @(posedge clk) begin
    if (!resetN) alarm_q <= 1'b0;
    else alarm_q <= alarm_set | (alarm_q & !alarmAck & alarmArm);
  end
  assign alarm = alarm_q;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = ^{alarmHour, alarmMinute, alarmArm, alarmAck};
  assign alarm = 1'b0;
`endif
  assign hour    = mode24 ? true_hour : true_hour == 6'd0 ? 6'd12 :
                   true_hour > 6'd12 ? true_hour - 6'd12 : true_hour;
  assign minute  = true_minute;
  assign second  = true_second;
  assign pm      = true_hour >= 6'd12;
  assign secTick = sec_tick_q;
  assign loadErr = load_err_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed vectors for time_keeper at CLK_FREQ_HZ=10.
module tb_time_keeper;
  logic clk = 1'b0, resetN, mode24, run, up, down, loadValid, alarmArm, alarmAck;
  logic [2:0] cursorPos;
  logic [5:0] loadHour, loadMinute, loadSecond, alarmHour, alarmMinute;
  logic [5:0] hour, minute, second;
  logic pm, secTick, loadErr, alarm;
  int vectors = 0, misses = 0;
`ifdef TIME_KEEPER_ALARM_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif
  time_keeper #(.CLK_FREQ_HZ(10), .CNT_W(4)) dut (
    .clk(clk), .resetN(resetN), .mode24(mode24), .run(run), .cursorPos(cursorPos),
    .up(up), .down(down), .loadValid(loadValid), .loadHour(loadHour),
    .loadMinute(loadMinute), .loadSecond(loadSecond), .alarmHour(alarmHour),
    .alarmMinute(alarmMinute), .alarmArm(alarmArm), .alarmAck(alarmAck),
    .hour(hour), .minute(minute), .second(second), .pm(pm), .secTick(secTick),
    .loadErr(loadErr), .alarm(alarm)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tm(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, hour, h);
    chk({tag, ".minute"}, minute, m);
    chk({tag, ".second"}, second, s);
  endtask
  task automatic load(input int h, input int m, input int s);
    loadHour = 6'(h);
    loadMinute = 6'(m);
    loadSecond = 6'(s);
    loadValid = 1'b1;
    step(1);
    loadValid = 1'b0;
  endtask
  initial begin
    resetN = 0; mode24 = 0; run = 0; up = 0; down = 0; loadValid = 0; cursorPos = 3'b000;
    loadHour = 0; loadMinute = 0; loadSecond = 0;
    alarmHour = 0; alarmMinute = 1; alarmArm = 0; alarmAck = 0;
    step(2);
    tm("reset", 12, 0, 0);
    chk("reset.pm", pm, 0);
    chk("reset.secTick", secTick, 0);
    chk("reset.loadErr", loadErr, 0);
    chk("reset.alarm", alarm, 0);
    mode24 = 1; #1;
    chk("reset.hour24", hour, 0);
    mode24 = 0;
    resetN = 1; run = 1;
    step(9);
    chk("first.early", secTick, 0);
    chk("first.sec0", second, 0);
    step(1);
    chk("first.tick", secTick, 1);
    chk("first.sec1", second, 1);
    step(1);
    chk("first.pulse", secTick, 0);
    step(9);
    chk("second.tick", secTick, 1);
    chk("second.sec2", second, 2);
    load(23, 59, 58);
    tm("load", 11, 59, 58);
    chk("load.pm", pm, 1);
    step(10);
    tm("roll1", 11, 59, 59);
    chk("roll1.tick", secTick, 1);
    step(10);
    tm("roll2", 12, 0, 0);
    chk("roll2.pm", pm, 0);
    chk("roll2.tick", secTick, 1);
    mode24 = 1; #1;
    chk("roll2.hour24", hour, 0);
    mode24 = 0;
    run = 0;
    cursorPos = 3'b010; down = 1; step(1); down = 0;
    tm("edit.down", 12, 59, 0);
    up = 1; step(1); up = 0;
    tm("edit.up", 12, 0, 0);
    cursorPos = 3'b101; up = 1; step(1); up = 0;
    tm("edit.badcur", 12, 0, 0);
    cursorPos = 3'b001; up = 1; down = 1; step(1); up = 0; down = 0;
    tm("edit.both", 12, 0, 0);
    loadHour = 5; loadMinute = 60; loadSecond = 5; loadValid = 1; step(1); loadValid = 0;
    chk("rej.loadErr", loadErr, 1);
    tm("rej", 12, 0, 0);
    step(1);
    chk("rej.pulse", loadErr, 0);
    load(0, 0, 10);
    run = 1;
    step(9);
    chk("tc.pre", second, 10);
    cursorPos = 3'b001; up = 1; step(1); up = 0;
    chk("tc.edit", second, 11);
    chk("tc.edit.tick", secTick, 0);
    step(1);
    chk("tc.defer", second, 12);
    chk("tc.defer.tick", secTick, 1);
    step(4);
    load(1, 2, 3);
    tm("mid.load", 1, 2, 3);
    chk("mid.pm", pm, 0);
    step(9);
    chk("mid.early", secTick, 0);
    step(1);
    chk("mid.tick", secTick, 1);
    chk("mid.sec", second, 4);
    alarmArm = 1;
    load(0, 0, 58);
    step(10);
    tm("al.pre", 12, 0, 59);
    chk("al.pre", alarm, 0);
    step(10);
    tm("al.hit", 12, 1, 0);
    chk("al.set", alarm, AL);
    step(3);
    chk("al.hold", alarm, AL);
    alarmAck = 1; step(1); alarmAck = 0;
    chk("al.ack", alarm, 0);
    step(2);
    chk("al.stay", alarm, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
# time_keeper

Parametrised real-time clock core for the Nixie clock. It generalises the current clock state storage block with a configurable prescaler and an exact one-second period. It provides range-checked parallel load, pause and up/down field editing with defined priorities, and an optional alarm. It sits between the input handler (cursor/up/down pulses) and the digit display path, feeding it hour/minute/second fields already formatted for 12- or 24-hour display.

## Interface
- CLK_FREQ_HZ, 100000000, input clock frequency; one second = CLK_FREQ_HZ cycles (minimum 4)
- CNT_W, 27, prescaler width; must satisfy 2^CNT_W > CLK_FREQ_HZ-1
- clk  in  1  system clock, all logic on rising edge
- resetN  in  1  synchronous, active-low reset
- mode24  in  1  1 = 24-hour output, 0 = 12-hour output
- run  in  1  1 = timekeeping advances, 0 = paused (prescaler frozen)
- cursorPos  in  3  one-hot edit field: 001 second, 010 minute, 100 hour; any other value = no field
- up, down  in  1  single-cycle edit pulses from the input handler
- loadValid  in  1  parallel-load request, single cycle
- loadHour, loadMinute, loadSecond  in  6 each  24-hour load value
- alarmHour, alarmMinute  in  6 each  24-hour alarm time (TIME_KEEPER_ALARM_EN only)
- alarmArm, alarmAck  in  1 each  alarm arm level / clear pulse (TIME_KEEPER_ALARM_EN only)
- hour, minute, second  out  6 each  current time; hour formatted per mode24
- pm  out  1  1 when the internal hour is 12..23, independent of mode24
- secTick  out  1  one-cycle pulse when the time advanced by the prescaler
- loadErr  out  1  one-cycle pulse when a load was rejected
- alarm  out  1  latched alarm flag

## Operation
- Internal state: 24-hour trueHour 0..23, trueMinute 0..59, trueSecond 0..59, prescaler cnt 0..CLK_FREQ_HZ-1, pendingTick, alarm.
- Reset (resetN=0 at edge): all state 0. Outputs: hour=12 if mode24=0, else 0. minute=0, second=0, pm=0, secTick=0, loadErr=0, alarm=0.
- Prescaler: when run=1, cnt increments. At cnt==CLK_FREQ_HZ-1 it wraps to 0 and raises a tick. When run=0, cnt holds and no tick is raised.
- Tick: second +1. 59→0 carries to minute. Minute 59→0 carries to hour. Hour 23→0. The full carry chain resolves in one cycle.
- Edit: up/down act on the cursor field only and never carry. Second/minute wrap 59↔0; hour wraps 23↔0. up and down together = no change. Invalid cursorPos = no change.
- Load: accepted only if loadHour≤23, loadMinute≤59 and loadSecond≤59. On accept, all three fields and cnt are written (cnt=0) and pendingTick is cleared. Otherwise state is unchanged and loadErr pulses.
- Priority per cycle: reset > load > edit > tick.
- A tick raised in the same cycle as an accepted edit sets pendingTick. A pending tick is applied on the next cycle with no load/edit, so no second is lost. A tick coinciding with an accepted load is discarded, because the load restarts the second.
- 12-hour format: internal 0→12, 1..12 unchanged, 13..23→1..11.
- Alarm: on an applied tick whose result is alarmHour:alarmMinute:00 with alarmArm=1, alarm sets. alarmAck or alarmArm=0 clears it. A set and an ack in the same cycle leave alarm set.

## Timing
- State registers update on the edge after the causing event. Outputs are combinational from state plus mode24, so latency from event to visible output = 1 cycle.
- secTick asserts in the cycle the advanced time is first visible, including a deferred pending tick.
- Second period: exactly CLK_FREQ_HZ cycles between secTick pulses with run=1 and no edits/loads.
- loadErr asserts 1 cycle after a rejected loadValid.
- mode24 changes affect hour in the same cycle and do not alter internal state.
- Reset mid-second clears cnt and pendingTick. The first secTick comes CLK_FREQ_HZ cycles after reset is released.

## Configuration
- TIME_KEEPER_ALARM_EN defined: alarm compare, latch and ack logic compiled in, as described above.
- Not defined: alarmHour/alarmMinute/alarmArm/alarmAck are ignored, alarm is tied to 0 and no alarm registers are built.

## Test plan
- CLK_FREQ_HZ=10: release reset, run=1 → secTick every 10 cycles, second 0→1→2. hour=12 with mode24=0, hour=0 with mode24=1, pm=0.
- Load 23:59:58, run 2 seconds → 23:59:59 then 00:00:00; pm 1→0; mode24=0 shows hour 11 then 12.
- cursorPos=010, minute=0: down → minute 59 with hour unchanged; up → 0. cursorPos=101 with up → no change.
- An up pulse in the same cycle as the prescaler terminal count, second=10, cursor=second → 11 next cycle, 12 the cycle after, with secTick on the second update.
- loadValid with loadMinute=60 → loadErr pulse, time unchanged. A valid load at cnt=5 → next secTick exactly 10 cycles later.
- With TIME_KEEPER_ALARM_EN: alarm 00:01, armed, start 00:00:58 → alarm sets on the tick to 00:01:00 and holds until an alarmAck pulse. Build without the macro → alarm stays 0.
